uart_tx: RTL
============

// Module: uart_tx
// PURPOSE
//  UART transmitter, 8N1 (8 data bits, no parity, STOP_BITS stop bits), LSB first.
//  Serialises bytes from a parallel valid/ready source onto o_Tx_Serial (idle high).
//  One-byte holding register allows back-to-back frames with no idle gap.
//  Pairs with the existing UART receiver at the far end of the serial line; same CLKS_PER_BIT.
// PARAMETERS
//  CLKS_PER_BIT  87  i_Clock cycles per serial bit (>=2); same value as the receiver.
//  STOP_BITS     1   number of stop bits, 1 or 2; any other value is a config error.
// PORTS
//  i_Clock      in   1  system clock, all logic on rising edge
//  i_Rst_n      in   1  asynchronous, active-low reset
//  i_Tx_DV      in   1  byte-valid strobe from source
//  i_Tx_Byte    in   8  byte to send; sampled on an edge where i_Tx_DV && o_Tx_Ready
//  o_Tx_Ready   out  1  holding register empty; byte accepted on the edge where DV && Ready
//  o_Tx_Active  out  1  high from first start-bit cycle to last stop-bit cycle
//  o_Tx_Serial  out  1  serial line; idle = 1
//  o_Tx_Done    out  1  one-cycle pulse after the final stop-bit cycle of each frame
// BEHAVIOUR
//  Reset (async assert, sync release): o_Tx_Serial=1, o_Tx_Ready=1, o_Tx_Active=0,
//   o_Tx_Done=0, holding reg empty, state IDLE, counters 0. Reset mid-frame aborts it:
//   line returns to 1 immediately, no o_Tx_Done, holding byte discarded.
//  All outputs registered. Bit counter width = $clog2(CLKS_PER_BIT).
//  Accept: edge E with i_Tx_DV && o_Tx_Ready -> byte into holding reg, o_Tx_Ready=0 after E.
//   i_Tx_DV while o_Tx_Ready=0 ignored; holding byte never overwritten.
//  FSM states: IDLE, START, DATA, STOP.
//   IDLE: line 1. If holding full: move byte to shift reg, free holding (Ready=1 next
//     cycle), -> START. Accept at E from IDLE => o_Tx_Serial=0, o_Tx_Active=1 after E+1.
//   START: line 0 for exactly CLKS_PER_BIT cycles -> DATA, bit index 0.
//   DATA: line = shift[idx] for CLKS_PER_BIT cycles each, idx 0..7, then -> STOP.
//   STOP: line 1 for STOP_BITS*CLKS_PER_BIT cycles. On last cycle: o_Tx_Done=1 next cycle;
//     if holding full -> load and go straight to START (no idle cycle, Active stays 1),
//     else -> IDLE, Active=0.
//  Frame length = (9+STOP_BITS)*CLKS_PER_BIT cycles, exact, no jitter.
//  Holding reg may be refilled while a frame is in flight (Ready=1 once byte moved to shifter).
//  Simultaneous: accept edge coincides with STOP->START load is impossible (Ready=0 then).
//  i_Tx_Byte changes after acceptance have no effect on the frame.
// STRUCTURE
//  Shared package uart_pkg: state encodings (IDLE/START/DATA/STOP), data width 8,
//   default CLKS_PER_BIT; receiver and transmitter both import it.
//  One natural sub-module: uart_baud_cnt (CLKS_PER_BIT down-counter, clear + terminal
//   tick); everything else in uart_tx.
// TESTING (CLKS_PER_BIT=4, STOP_BITS=1 unless stated; loopback into receiver where noted)
//  1 Reset: hold i_Rst_n=0 -> Serial=1, Ready=1, Active=0, Done=0; release, no DV -> stays idle.
//  2 Send 0xA5 -> line 0,1,0,1,0,0,1,0,1,1 each held 4 cycles; Done pulses once 40 cycles
//    after Serial fell; receiver loopback reports 0xA5.
//  3 Back-to-back 0x00 then 0xFF (2nd DV as soon as Ready) -> 80 contiguous cycles, no idle
//    gap, Active high throughout, two Done pulses 40 cycles apart.
//  4 DV held high with 0x3C while Ready=0 -> byte accepted only once Ready=1; no byte
//    dropped or duplicated, exactly expected frames on line.
//  5 Assert i_Rst_n=0 mid-DATA of 0x81 -> Serial=1 same cycle (async), no Done; next
//    0x55 transmits cleanly.
//  6 STOP_BITS=2, send 0x0F -> stop high 8 cycles, frame 44 cycles, Done at end.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions for the transmitter and receiver
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 87;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period down-counter with clear and terminal tick
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int                  CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LOAD  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Reload on terminal count so consecutive bits need no explicit restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || (cnt == '0)) begin
      cnt <= LOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with one-byte holding register
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done
);

  localparam int               IDX_W     = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx: CLKS_PER_BIT must be at least 2");
  end

  uart_state_t          state;
  logic [DATA_BITS-1:0] hold;
  logic [DATA_BITS-1:0] shift;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_next;
  logic                 tick;

  assign idx_next = idx + 1'b1;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk  (i_Clock),
    .rst_n(i_Rst_n),
    .clear(state == IDLE),
    .tick (tick)
  );

  // o_Tx_Ready doubles as the holding-register-empty flag.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= IDLE;
      hold        <= '0;
      shift       <= '0;
      idx         <= '0;
      o_Tx_Ready  <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Done   <= 1'b0;
    end else begin
      o_Tx_Done <= 1'b0;

      if (i_Tx_DV && o_Tx_Ready) begin
        hold       <= i_Tx_Byte;
        o_Tx_Ready <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!o_Tx_Ready) begin
            shift       <= hold;
            o_Tx_Ready  <= 1'b1;
            o_Tx_Active <= 1'b1;
            o_Tx_Serial <= 1'b0;
            state       <= START;
          end
        end

        START: begin
          if (tick) begin
            idx         <= '0;
            o_Tx_Serial <= shift[0];
            state       <= DATA;
          end
        end

        DATA: begin
          if (tick) begin
            if (idx == LAST_DATA) begin
              idx         <= '0;
              o_Tx_Serial <= 1'b1;
              state       <= STOP;
            end else begin
              idx         <= idx_next;
              o_Tx_Serial <= shift[idx_next];
            end
          end
        end

        STOP: begin
          if (tick) begin
            if (idx == LAST_STOP) begin
              idx       <= '0;
              o_Tx_Done <= 1'b1;
              // A waiting byte starts its frame with no idle cycle in between.
              if (!o_Tx_Ready) begin
                shift       <= hold;
                o_Tx_Ready  <= 1'b1;
                o_Tx_Serial <= 1'b0;
                state       <= START;
              end else begin
                o_Tx_Active <= 1'b0;
                state       <= IDLE;
              end
            end else begin
              idx <= idx_next;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
